// File: rtl/bcd_serializer.sv
// BCD digit serializer: a small digit FIFO feeding a 4-bit shift register
// that emits one digit every four cycles, LSB first, with filler frames
// (digit_valid low) whenever the FIFO is empty.
// Optional build macro: BCD_CHECK_EN rejects digits above 9 and raises a
// sticky err flag; without it err is tied low and any 4-bit code is sent.
module bcd_serializer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               in_digit,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     ser_out,
  output logic                     frame_start,
  output logic                     digit_valid,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {B0, B1, B2, B3} phase_t;

  phase_t          phase;
  phase_t          phase_next;
  logic [3:0]      shreg;
  logic            dv_q;
  logic [3:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            store;
  logic            pop;
  logic            digit_ok;

  // The handshake completes whenever there is room; only acceptable digits
  // are actually written, and the head is consumed on every B3 edge.
  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid && in_ready;
`ifdef BCD_CHECK_EN
  assign digit_ok = (in_digit <= 4'd9);
`else
  assign digit_ok = 1'b1;
`endif
  assign store    = push && digit_ok;
  assign pop      = (phase == B3) && (count != '0);

  assign ser_out     = shreg[0];
  assign digit_valid = dv_q;
  assign fifo_count  = count;

  // Phase register: free-running frame counter, cleared to B0 on reset.
  always_ff @(posedge clk) begin
    if (!reset) phase <= B0;
    else        phase <= phase_next;
  end

  // Phase sequencing never stalls; frame_start marks the first bit slot.
  always_comb begin
    phase_next  = B0;
    frame_start = 1'b0;
    case (phase)
      B0: begin
        phase_next  = B1;
        frame_start = 1'b1;
      end
      B1:      phase_next = B2;
      B2:      phase_next = B3;
      B3:      phase_next = B0;
      default: phase_next = B0;
    endcase
  end

  // Digit storage; stale contents are harmless since pointers are reset.
  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= in_digit;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({store, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Shift register: load the head (or filler) in B3, shift right otherwise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg <= 4'b0000;
      dv_q  <= 1'b0;
    end else if (phase == B3) begin
      if (count != '0) begin
        shreg <= mem[rd_ptr];
        dv_q  <= 1'b1;
      end else begin
        shreg <= 4'b0000;
        dv_q  <= 1'b0;
      end
    end else begin
      shreg <= {1'b0, shreg[3:1]};
    end
  end

`ifdef BCD_CHECK_EN
  logic err_q;

  // Sticky error: any rejected digit latches err until the next reset.
  always_ff @(posedge clk) begin
    if (!reset)                err_q <= 1'b0;
    else if (push && !digit_ok) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serializer.sv
// Directed self-checking bench for bcd_serializer (DEPTH=4). Inputs are
// driven and outputs sampled on the falling clock edge.
module tb_bcd_serializer;

  logic       clk;
  logic       reset;
  logic [3:0] in_digit;
  logic       in_valid;
  logic       in_ready;
  logic       ser_out;
  logic       frame_start;
  logic       digit_valid;
  logic [2:0] fifo_count;
  logic       err;

  int tests_run;
  int tests_failed;

  bcd_serializer #(.DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_digit    (in_digit),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ser_out     (ser_out),
    .frame_start (frame_start),
    .digit_valid (digit_valid),
    .fifo_count  (fifo_count),
    .err         (err)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold reset for two edges, release on a falling edge (phase B0 state).
  task automatic apply_reset();
    reset    = 1'b0;
    in_valid = 1'b0;
    in_digit = 4'd0;
    step();
    step();
    reset = 1'b1;
  endtask

  // Starting in B0, check the four bit slots of one frame and end in B0.
  task automatic check_frame(input string tag, input logic [3:0] d, input logic dv);
    for (int i = 0; i < 4; i++) begin
      check_output({tag, "_fs"}, {7'd0, frame_start}, {7'd0, (i == 0)});
      check_output({tag, "_bit"}, {7'd0, ser_out}, {7'd0, d[i]});
      check_output({tag, "_dv"}, {7'd0, digit_valid}, {7'd0, dv});
      step();
    end
  endtask

  // Idle cycles from B0: filler only, frame_start every fourth cycle.
  task automatic check_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check_output({tag, "_fs"}, {7'd0, frame_start}, {7'd0, (i % 4 == 0)});
      check_output({tag, "_ser"}, {7'd0, ser_out}, 8'd0);
      check_output({tag, "_dv"}, {7'd0, digit_valid}, 8'd0);
      step();
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    in_valid     = 1'b0;
    in_digit     = 4'd0;

    // Reset state and idle behaviour.
    apply_reset();
    check_output("rst_fs", {7'd0, frame_start}, 8'd1);
    check_output("rst_ser", {7'd0, ser_out}, 8'd0);
    check_output("rst_rdy", {7'd0, in_ready}, 8'd1);
    check_output("rst_cnt", {5'd0, fifo_count}, 8'd0);
    check_output("rst_err", {7'd0, err}, 8'd0);
    check_idle("idle", 8);

    // Single digit 5 pushed in B2 appears in the very next frame.
    apply_reset();
    step();
    step();
    in_valid = 1'b1;
    in_digit = 4'd5;
    step();
    in_valid = 1'b0;
    check_output("d5_cnt", {5'd0, fifo_count}, 8'd1);
    step();
    check_frame("d5", 4'b0101, 1'b1);
    check_output("d5_after_cnt", {5'd0, fifo_count}, 8'd0);
    check_frame("d5_fill", 4'b0000, 1'b0);

    // Fill the FIFO with 1,2,3,4 starting on a B3 edge, then hold a push.
    apply_reset();
    step();
    step();
    step();
    in_valid = 1'b1;
    in_digit = 4'd1; step();
    in_digit = 4'd2; step();
    in_digit = 4'd3; step();
    in_digit = 4'd4; step();
    check_output("full_cnt", {5'd0, fifo_count}, 8'd4);
    check_output("full_rdy", {7'd0, in_ready}, 8'd0);
    in_digit = 4'd6;
    step();
    check_output("pop_cnt", {5'd0, fifo_count}, 8'd3);
    check_output("pop_rdy", {7'd0, in_ready}, 8'd1);
    check_output("d1_fs", {7'd0, frame_start}, 8'd1);
    check_output("d1_bit0", {7'd0, ser_out}, 8'd1);
    check_output("d1_dv", {7'd0, digit_valid}, 8'd1);
    step();
    check_output("refill_cnt", {5'd0, fifo_count}, 8'd4);
    check_output("refill_rdy", {7'd0, in_ready}, 8'd0);
    check_output("d1_bit1", {7'd0, ser_out}, 8'd0);
    step();
    check_output("hold_cnt", {5'd0, fifo_count}, 8'd4);
    in_valid = 1'b0;
    step();
    step();
    check_frame("d2", 4'd2, 1'b1);
    check_frame("d3", 4'd3, 1'b1);
    check_frame("d4", 4'd4, 1'b1);
    check_frame("d6", 4'd6, 1'b1);
    check_output("drain_cnt", {5'd0, fifo_count}, 8'd0);
    check_frame("drain_fill", 4'b0000, 1'b0);

    // Digit 9 interrupted by reset in B1 of its frame.
    apply_reset();
    step();
    step();
    in_valid = 1'b1;
    in_digit = 4'd9;
    step();
    in_valid = 1'b0;
    step();
    check_output("d9_bit0", {7'd0, ser_out}, 8'd1);
    check_output("d9_dv", {7'd0, digit_valid}, 8'd1);
    step();
    check_output("d9_bit1", {7'd0, ser_out}, 8'd0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check_output("mid_rst_fs", {7'd0, frame_start}, 8'd1);
    check_output("mid_rst_ser", {7'd0, ser_out}, 8'd0);
    check_output("mid_rst_rdy", {7'd0, in_ready}, 8'd1);
    check_output("mid_rst_dv", {7'd0, digit_valid}, 8'd0);
    check_output("mid_rst_cnt", {5'd0, fifo_count}, 8'd0);
    check_idle("post_rst", 8);

    // Out-of-range digit 12 followed by 7.
    apply_reset();
    step();
    step();
    in_valid = 1'b1;
    in_digit = 4'd12;
    step();
`ifdef BCD_CHECK_EN
    check_output("chk_err", {7'd0, err}, 8'd1);
    check_output("chk_cnt", {5'd0, fifo_count}, 8'd0);
    in_digit = 4'd7;
    step();
    in_valid = 1'b0;
    check_frame("chk_fill", 4'b0000, 1'b0);
    check_frame("chk_d7", 4'd7, 1'b1);
    check_output("chk_err_sticky", {7'd0, err}, 8'd1);
`else
    in_valid = 1'b0;
    check_output("nochk_err", {7'd0, err}, 8'd0);
    check_output("nochk_cnt", {5'd0, fifo_count}, 8'd1);
    step();
    check_frame("nochk_d12", 4'd12, 1'b1);
    check_output("nochk_err_end", {7'd0, err}, 8'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
